chunked_cla_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor for the RV64F datapath; next generation of the 1-bit partial full adder.
- Each cycle adds one BLOCK-bit chunk with an internal carry-lookahead block built from per-bit propagate (a|b) and generate (a&b) terms, registering the carry between chunks.
- Valid/ready handshake at input and output, so it can sit between pipeline stages or feed the FPU mantissa path.

---
 rtl/chunked_cla_adder.sv | 116 +++++++++++
 tb/tb_chunked_cla_adder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_cla_adder.sv
// chunked_cla_adder: multi-cycle adder/subtractor, one BLOCK-bit carry-lookahead chunk per cycle
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, c_i, sub sampled on acceptance)
//   a, b                  WIDTH-bit operands
//   c_i                   carry in (ignored when sub=1)
//   sub                   0: a+b+c_i, 1: a-b
//   out_valid / out_ready result handshake
//   s                     WIDTH-bit sum/difference
//   c_o                   carry out of MSB (sub: 1 = no borrow)
//   ovf                   signed overflow
//   p, g                  group propagate / generate over the effective operands
module chunked_cla_adder #(
    parameter int WIDTH = 64,
    parameter int BLOCK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_i,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_o,
    output logic             ovf,
    output logic             p,
    output logic             g
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int CW = NBLK > 1 ? $clog2(NBLK) : 1;

    if (BLOCK < 1 || WIDTH < BLOCK || WIDTH % BLOCK != 0) begin : g_bad_params
        $fatal(1, "chunked_cla_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, nxt;
    logic             live;
    logic [WIDTH-1:0] a_r, b_r;
    logic [CW-1:0]    cnt;
    logic [BLOCK-1:0] ca, cb, sum;
    logic [BLOCK:0]   c, gc;
    logic             last, accept;
    int               base;

    // c_o, g and p double as the running carry, the zero-carry-in carry and the
    // propagate accumulator; they only settle to their final meaning in DONE.
    always_comb begin
        base   = int'(cnt) * BLOCK;
        ca     = a_r[base +: BLOCK];
        cb     = b_r[base +: BLOCK];
        c      = '0;
        gc     = '0;
        sum    = '0;
        c[0]   = c_o;
        gc[0]  = g;
        for (int j = 0; j < BLOCK; j++) begin
            c[j+1]  = (ca[j] & cb[j]) | ((ca[j] | cb[j]) & c[j]);
            gc[j+1] = (ca[j] & cb[j]) | ((ca[j] | cb[j]) & gc[j]);
            sum[j]  = ca[j] ^ cb[j] ^ c[j];
        end
    end

    always_comb begin
        in_ready  = live && state == IDLE;
        out_valid = state == DONE;
        last      = cnt == CW'(NBLK - 1);
        accept    = in_valid && in_ready;
        nxt       = state;
        case (state)
            IDLE:    nxt = accept ? CALC : IDLE;
            CALC:    nxt = last ? DONE : CALC;
            DONE:    nxt = out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            live  <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            cnt   <= '0;
            s     <= '0;
            c_o   <= 1'b0;
            ovf   <= 1'b0;
            p     <= 1'b0;
            g     <= 1'b0;
        end else begin
            state <= nxt;
            live  <= 1'b1;
            if (accept) begin
                a_r <= a;
                b_r <= sub ? ~b : b;
                c_o <= sub | c_i;
                g   <= 1'b0;
                p   <= 1'b1;
                cnt <= '0;
            end else if (state == CALC) begin
                s[base +: BLOCK] <= sum;
                c_o <= c[BLOCK];
                g   <= gc[BLOCK];
                p   <= p & (&(ca | cb));
                cnt <= last ? '0 : cnt + CW'(1);
                if (last) ovf <= c[BLOCK] ^ c[BLOCK-1];
            end
        end
    end
endmodule

// File: tb/tb_chunked_cla_adder.sv
// tb_chunked_cla_adder: directed table, reset/backpressure sequences and random regression at BLOCK=16, 8, 64
module tb_chunked_cla_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv[3], ir[3], ov[3], ordy[3], ci[3], sb[3], co[3], of[3], pp[3], gg[3];
    logic [63:0] av[3], bv[3], sv[3];
    int          ncmp = 0, nerr = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        chunked_cla_adder #(.WIDTH(64), .BLOCK(i == 0 ? 16 : (i == 1 ? 8 : 64))) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(iv[i]), .in_ready(ir[i]),
            .a(av[i]), .b(bv[i]), .c_i(ci[i]), .sub(sb[i]),
            .out_valid(ov[i]), .out_ready(ordy[i]), .s(sv[i]), .c_o(co[i]),
            .ovf(of[i]), .p(pp[i]), .g(gg[i])
        );
    end

    typedef struct {
        logic [63:0] a, b;
        logic        ci, sub;
        logic [63:0] s;
        logic        co, ovf, p, g;
    } vec_t;

    vec_t tv[7];

    function automatic int nblk(input int k);
        return k == 0 ? 4 : (k == 1 ? 8 : 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the effective operands.
    task automatic model(input logic [63:0] ma, mb, input logic mci, msub,
                         output logic [63:0] ms, output logic mco, movf, mp, mg);
        logic [63:0] bb;
        logic [64:0] r, r0;
        bb   = msub ? ~mb : mb;
        r    = {1'b0, ma} + {1'b0, bb} + 65'(msub ? 1'b1 : mci);
        r0   = {1'b0, ma} + {1'b0, bb};
        ms   = r[63:0];
        mco  = r[64];
        movf = (ma[63] == bb[63]) && (ms[63] != ma[63]);
        mp   = &(ma | bb);
        mg   = r0[64];
    endtask

    task automatic run_op(input int k, input logic [63:0] ta, tb_, input logic tci, tsub,
                          input int stall, input bit rnd_ready,
                          output logic [63:0] rs, output logic rco, rovf, rp, rg);
        int          n;
        logic [63:0] snap;
        n = 0;
        while (!ir[k] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_wait", 64'(ir[k]), 64'd1);
        av[k] = ta;
        bv[k] = tb_;
        ci[k] = tci;
        sb[k] = tsub;
        iv[k] = 1'b1;
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        av[k] = {$urandom, $urandom};
        bv[k] = {$urandom, $urandom};
        ci[k] = 1'($urandom);
        sb[k] = 1'($urandom);
        n = 0;
        while (!ov[k] && n < 100) begin
            ordy[k] = rnd_ready ? 1'($urandom) : 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        ordy[k] = 1'b0;
        chk("latency", 64'(n), 64'(nblk(k)));
        snap = sv[k];
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 64'(ov[k]), 64'd1);
            chk("stall_s", sv[k], snap);
        end
        rs   = sv[k];
        rco  = co[k];
        rovf = of[k];
        rp   = pp[k];
        rg   = gg[k];
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
        chk("valid_drop", 64'(ov[k]), 64'd0);
    endtask

    initial begin
        logic [63:0] rs, es, ra, rb;
        logic        rco, rovf, rp, rg, eco, eovf, ep, eg, rci, rsub;
        int          n;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; ci[k] = 1'b0; sb[k] = 1'b0;
            av[k] = '0; bv[k] = '0;
        end
        tv[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1};
        tv[3] = '{64'd3, 64'd5, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[4] = '{64'd5, 64'd3, 1'b1, 1'b0, 64'd9, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b1};
        tv[6] = '{64'd10, 64'd10, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};

        #1;
        chk("reset_in_ready", 64'(ir[0]), 64'd0);
        chk("reset_out_valid", 64'(ov[0]), 64'd0);
        chk("reset_s", sv[0], 64'd0);
        chk("reset_flags", {60'd0, co[0], of[0], pp[0], gg[0]}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("in_ready_pre_clk", 64'(ir[0]), 64'd0);
        @(posedge clk);
        #1;
        chk("in_ready_after_release", 64'(ir[0]), 64'd1);

        for (int k = 0; k < 3; k++)
            for (int v = 0; v < 7; v++) begin
                run_op(k, tv[v].a, tv[v].b, tv[v].ci, tv[v].sub, v % 3, 1'b0, rs, rco, rovf, rp, rg);
                chk($sformatf("vec%0d_k%0d_s", v, k), rs, tv[v].s);
                chk($sformatf("vec%0d_k%0d_flags", v, k), {60'd0, rco, rovf, rp, rg},
                    {60'd0, tv[v].co, tv[v].ovf, tv[v].p, tv[v].g});
            end

        // reset two cycles into an operation
        av[0] = 64'd5; bv[0] = 64'd3; ci[0] = 1'b0; sb[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(ov[0]), 64'd0);
        chk("midreset_s", sv[0], 64'd0);
        chk("midreset_in_ready", 64'(ir[0]), 64'd0);
        chk("midreset_flags", {60'd0, co[0], of[0], pp[0], gg[0]}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_in_ready_after", 64'(ir[0]), 64'd1);
        n = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            n += int'(ov[0]);
        end
        chk("midreset_no_result", 64'(n), 64'd0);

        // backpressure with a second request held pending
        av[0] = 64'd5; bv[0] = 64'd3; ci[0] = 1'b0; sb[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1;
        av[0] = 64'd100; bv[0] = 64'd1; ci[0] = 1'b1; sb[0] = 1'b1;
        n = 0;
        while (!ov[0] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_latency", 64'(n), 64'd4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 64'(ov[0]), 64'd1);
            chk("bp_s", sv[0], 64'd8);
            chk("bp_in_ready", 64'(ir[0]), 64'd0);
        end
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        chk("bp_idle_valid", 64'(ov[0]), 64'd0);
        chk("bp_idle_ready", 64'(ir[0]), 64'd1);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        chk("bp_second_accepted", 64'(ir[0]), 64'd0);
        n = 0;
        while (!ov[0] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_second_s", sv[0], 64'd99);
        chk("bp_second_co", 64'(co[0]), 64'd1);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 1000; i++) begin
                ra   = {$urandom, $urandom};
                rb   = {$urandom, $urandom};
                rci  = 1'($urandom);
                rsub = 1'($urandom);
                if (i % 10 == 0) rb = ~ra;
                model(ra, rb, rci, rsub, es, eco, eovf, ep, eg);
                run_op(k, ra, rb, rci, rsub, $urandom_range(0, 3), 1'b1, rs, rco, rovf, rp, rg);
                chk($sformatf("rand_k%0d_s", k), rs, es);
                chk($sformatf("rand_k%0d_flags", k), {60'd0, rco, rovf, rp, rg},
                    {60'd0, eco, eovf, ep, eg});
            end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
